// File: rtl/mips_pkg.sv
// rtl/mips_pkg.sv - shared types for the posted-write buffer
// Purpose: drain state enum and FIFO entry layout used by avalon_write_buffer and wb_fifo.
// Ports: none (package).
package mips_pkg;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int BE_W   = 4;

  typedef enum logic {
    IDLE  = 1'b0,
    DRAIN = 1'b1
  } wb_state_t;

  typedef struct packed {
    logic [ADDR_W-1:0] address;
    logic [BE_W-1:0]   byteenable;
    logic [DATA_W-1:0] writedata;
  } wb_entry_t;

endpackage

// File: rtl/wb_fifo.sv
// rtl/wb_fifo.sv - posted-write FIFO storage and pointers
// Purpose: DEPTH-entry circular buffer of write entries with head/tail pointers and occupancy count.
// Ports:
//   clk, reset          clock, asynchronous active-low reset (clears pointers and count)
//   push, push_entry    enqueue request and entry (ignored when full)
//   pop                 retire head entry (ignored when empty)
//   head_entry          entry at the head pointer
//   count, empty, full  occupancy status
module wb_fifo
  import mips_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  wb_entry_t        push_entry,
  input  logic             pop,
  output wb_entry_t        head_entry,
  output logic [CNT_W-1:0] count,
  output logic             empty,
  output logic             full
);

  localparam int PTR_W = $clog2(DEPTH);

  wb_entry_t        mem [DEPTH];
  logic [PTR_W-1:0] head;
  logic [PTR_W-1:0] tail;
  logic             push_ok;
  logic             pop_ok;

  assign empty   = (count == '0);
  assign full    = (count == CNT_W'(DEPTH));
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;

  // Storage is not reset; only the pointers decide which entries are live.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[tail] <= push_entry;
    end
  end

  // DEPTH is a power of two, so natural pointer overflow gives the modulo wrap.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (push_ok) begin
        tail <= tail + PTR_W'(1);
      end
      if (pop_ok) begin
        head <= head + PTR_W'(1);
      end
      case ({push_ok, pop_ok})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  assign head_entry = mem[head];

endmodule

// File: rtl/avalon_write_buffer.sv
// rtl/avalon_write_buffer.sv - posted-write buffer between a CPU master and a memory slave
// Purpose: accepts CPU writes into a FIFO and drains them to memory; reads pass straight
//          through when no write is pending, and otherwise stall until the FIFO empties.
// Ports:
//   clk, reset                                    clock, asynchronous active-low reset
//   s_address/s_byteenable/s_read/s_write/
//   s_writedata/s_waitrequest/s_readdata          CPU-side slave port
//   m_address/m_byteenable/m_read/m_write/
//   m_writedata/m_waitrequest/m_readdata          memory-side master port
//   wb_empty                                      high when no posted write is pending
module avalon_write_buffer
  import mips_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] s_address,
  input  logic [3:0]  s_byteenable,
  input  logic        s_read,
  input  logic        s_write,
  input  logic [31:0] s_writedata,
  output logic        s_waitrequest,
  output logic [31:0] s_readdata,
  output logic [31:0] m_address,
  output logic [3:0]  m_byteenable,
  output logic        m_read,
  output logic        m_write,
  output logic [31:0] m_writedata,
  input  logic        m_waitrequest,
  input  logic [31:0] m_readdata,
  output logic        wb_empty
);

  localparam int CNT_W = $clog2(DEPTH + 1);

  wb_state_t        state;
  wb_entry_t        push_entry;
  wb_entry_t        head_entry;
  logic [CNT_W-1:0] count;
  logic             fifo_empty;
  logic             fifo_full;
  logic             push;
  logic             pop;
  logic             rd_pass;

  assign push_entry = {s_address, s_byteenable, s_writedata};

  // A full FIFO refuses the write even if the head retires this cycle.
  assign push = s_write && !fifo_full;
  assign pop  = (state == DRAIN) && !m_waitrequest;

  // Reads only pass through with nothing posted; a simultaneous write wins.
  // Gating with reset keeps the memory port quiet while reset is held.
  assign rd_pass = reset && s_read && !s_write && (state == IDLE);

  wb_fifo #(
    .DEPTH (DEPTH),
    .CNT_W (CNT_W)
  ) u_fifo (
    .clk        (clk),
    .reset      (reset),
    .push       (push),
    .push_entry (push_entry),
    .pop        (pop),
    .head_entry (head_entry),
    .count      (count),
    .empty      (fifo_empty),
    .full       (fifo_full)
  );

  // DRAIN tracks count>0; it leaves only when the last entry retires with no new write.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      case (state)
        IDLE:    if (push) state <= DRAIN;
        DRAIN:   if (pop && (count == CNT_W'(1)) && !push) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  always_comb begin
    m_address    = '0;
    m_byteenable = '0;
    m_writedata  = '0;
    m_write      = 1'b0;
    m_read       = 1'b0;
    if (state == DRAIN) begin
      m_write      = 1'b1;
      m_address    = head_entry.address;
      m_byteenable = head_entry.byteenable;
      m_writedata  = head_entry.writedata;
    end else if (rd_pass) begin
      m_read       = 1'b1;
      m_address    = s_address;
      m_byteenable = s_byteenable;
    end
  end

  always_comb begin
    s_waitrequest = 1'b0;
    if (reset) begin
      if (s_write) begin
        s_waitrequest = fifo_full;
      end else if (s_read) begin
        s_waitrequest = rd_pass ? m_waitrequest : 1'b1;
      end
    end
  end

  assign s_readdata = rd_pass ? m_readdata : 32'h0;
  assign wb_empty   = fifo_empty;

endmodule
